// File: rtl/sevenseg_scan_ctl.sv
// sevenseg_scan_ctl: multiplexed common-anode seven-segment scan controller.
// Scans NDIGITS digits, each selected for SLOT_CYCLES clocks. The controller
// supports per-digit decimal points, a per-digit enable mask and 16-level PWM
// brightness. It captures its inputs only at frame boundaries, so a frame on
// the display never mixes old and new values.
// Optional feature: define SEVENSEG_LZB_EN to enable leading-zero blanking.
// Valid/ready: none; inputs are level-sampled at frame boundaries, and the
// outputs are registered pin levels.
module sevenseg_scan_ctl #(
  parameter int NDIGITS     = 8,
  parameter int SLOT_CYCLES = 100000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [4*NDIGITS-1:0] data,
  input  logic [NDIGITS-1:0]   dp,
  input  logic [NDIGITS-1:0]   dig_en,
  input  logic [3:0]           bright,
  output logic [6:0]           segs_n,
  output logic                 dp_n,
  output logic [NDIGITS-1:0]   an_n,
  output logic                 frame_tick
);

  localparam int SCW  = $clog2(SLOT_CYCLES);
  localparam int IDXW = $clog2(NDIGITS);
  localparam logic [SCW-1:0]  SC_LAST  = SCW'(SLOT_CYCLES - 1);
  localparam logic [IDXW-1:0] IDX_LAST = IDXW'(NDIGITS - 1);
  localparam logic [NDIGITS-1:0] ONE_HOT0 = NDIGITS'(1);

  // Active-high hex decode, bit order {g,f,e,d,c,b,a}.
  function automatic logic [6:0] hex_seg(input logic [3:0] v);
    case (v)
      4'h0: hex_seg = 7'h3F;
      4'h1: hex_seg = 7'h06;
      4'h2: hex_seg = 7'h5B;
      4'h3: hex_seg = 7'h4F;
      4'h4: hex_seg = 7'h66;
      4'h5: hex_seg = 7'h6D;
      4'h6: hex_seg = 7'h7D;
      4'h7: hex_seg = 7'h07;
      4'h8: hex_seg = 7'h7F;
      4'h9: hex_seg = 7'h6F;
      4'hA: hex_seg = 7'h77;
      4'hB: hex_seg = 7'h7C;
      4'hC: hex_seg = 7'h39;
      4'hD: hex_seg = 7'h5E;
      4'hE: hex_seg = 7'h79;
      default: hex_seg = 7'h71;
    endcase
  endfunction

  // Scan state and frame-synchronous shadow copies of the inputs.
  logic [SCW-1:0]       sc_q, sc_d;
  logic [IDXW-1:0]      idx_q, idx_d;
  logic [3:0]           pwm_q, pwm_d;
  logic [4*NDIGITS-1:0] sh_data_q, sh_data_d;
  logic [NDIGITS-1:0]   sh_dp_q, sh_dp_d;
  logic [NDIGITS-1:0]   sh_en_q, sh_en_d;
  logic [3:0]           sh_bright_q, sh_bright_d;
  // start_q forces a frame boundary on the first cycle out of reset.
  logic                 start_q;
  // loaded_q marks the state cycle right after a shadow load (digit 0 begins).
  logic                 loaded_q, loaded_d;
  logic                 boundary;

  // Registered pin drivers.
  logic [6:0]           segs_q, segs_d;
  logic                 dp_n_q, dp_n_d;
  logic [NDIGITS-1:0]   an_n_q, an_n_d;
  logic                 frame_q, frame_d;

  logic [NDIGITS-1:0]   eff_en;
  logic [3:0]           cur_val;
  logic                 lit;

`ifdef SEVENSEG_LZB_EN
  logic [NDIGITS-1:0] lzb_mask;
  logic               higher_zero;
  // Blank zero digits above the most significant nonzero enabled digit.
  always_comb begin
    lzb_mask    = '0;
    higher_zero = 1'b1;
    for (int i = NDIGITS - 1; i > 0; i--) begin
      if (higher_zero && (sh_data_q[4*i +: 4] == 4'h0)) lzb_mask[i] = 1'b1;
      higher_zero = higher_zero && ((sh_data_q[4*i +: 4] == 4'h0) || !sh_en_q[i]);
    end
  end
  assign eff_en = sh_en_q & ~lzb_mask;
`else
  assign eff_en = sh_en_q;
`endif

  // Next-state logic: slot/digit counters, PWM, and the shadow load at frame boundaries.
  always_comb begin
    sc_d        = sc_q;
    idx_d       = idx_q;
    pwm_d       = pwm_q + 4'd1;
    sh_data_d   = sh_data_q;
    sh_dp_d     = sh_dp_q;
    sh_en_d     = sh_en_q;
    sh_bright_d = sh_bright_q;
    boundary    = start_q || ((sc_q == SC_LAST) && (idx_q == IDX_LAST));
    loaded_d    = boundary;
    if (boundary) begin
      sc_d        = '0;
      idx_d       = '0;
      sh_data_d   = data;
      sh_dp_d     = dp;
      sh_en_d     = dig_en;
      sh_bright_d = bright;
    end else if (sc_q == SC_LAST) begin
      sc_d  = '0;
      idx_d = idx_q + 1'b1;
    end else begin
      sc_d = sc_q + 1'b1;
    end
  end

  // Output decode from the current state; every pin comes from the same state, so anodes and segments change together.
  always_comb begin
    cur_val = sh_data_q[4*int'(idx_q) +: 4];
    lit     = eff_en[idx_q] && (pwm_q <= sh_bright_q);
    an_n_d  = '1;
    segs_d  = 7'h7F;
    dp_n_d  = 1'b1;
    frame_d = loaded_q;
    if (lit) begin
      an_n_d = ~(ONE_HOT0 << idx_q);
      segs_d = ~hex_seg(cur_val);
      dp_n_d = ~sh_dp_q[idx_q];
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      sc_q        <= '0;
      idx_q       <= '0;
      pwm_q       <= '0;
      sh_data_q   <= '0;
      sh_dp_q     <= '0;
      sh_en_q     <= '0;
      sh_bright_q <= '0;
      start_q     <= 1'b1;
      loaded_q    <= 1'b0;
      segs_q      <= 7'h7F;
      dp_n_q      <= 1'b1;
      an_n_q      <= '1;
      frame_q     <= 1'b0;
    end else begin
      sc_q        <= sc_d;
      idx_q       <= idx_d;
      pwm_q       <= pwm_d;
      sh_data_q   <= sh_data_d;
      sh_dp_q     <= sh_dp_d;
      sh_en_q     <= sh_en_d;
      sh_bright_q <= sh_bright_d;
      start_q     <= 1'b0;
      loaded_q    <= loaded_d;
      segs_q      <= segs_d;
      dp_n_q      <= dp_n_d;
      an_n_q      <= an_n_d;
      frame_q     <= frame_d;
    end
  end

  assign segs_n     = segs_q;
  assign dp_n       = dp_n_q;
  assign an_n       = an_n_q;
  assign frame_tick = frame_q;

endmodule
